// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with registered,
// blank-gated RGB and sync outputs driven from a divided pixel tick.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 4,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               pix_tick,
    output logic               pix_req,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [X_W-1:0] X_MAX   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] XA      = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEG  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END  = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] YA      = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEG  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]      div_q, div_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               tick_q, tick_d, run_q, run_d, ls_q, ls_d, fs_q, fs_d;
    logic               hs_q, hs_d, vs_q, vs_d, upd, x_end, y_end;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    // The first tick after idle starts the raster at (0,0) without advancing,
    // so pixel (0,0) gets a full request period and the start strobes fire.
    always_comb begin
        pix_req = (x_q < XA) && (y_q < YA);
        tick_d  = enable && (div_q == DIV_MAX);
        div_d   = (!enable || tick_d) ? '0 : div_q + 1'b1;
        run_d   = enable && (run_q || tick_d);
        upd     = tick_d && run_q;
        x_end   = x_q == X_MAX;
        y_end   = y_q == Y_MAX;
        x_d     = !run_d ? '0 : !upd ? x_q : x_end ? '0 : x_q + 1'b1;
        y_d     = !run_d ? '0 : (upd && x_end) ? (y_end ? '0 : y_q + 1'b1) : y_q;
        ls_d    = tick_d && (x_d == '0);
        fs_d    = ls_d && (y_d == '0);
        hs_d    = !enable ? ~H_POL : upd ? ((x_q >= HS_BEG && x_q < HS_END) ? H_POL : ~H_POL) : hs_q;
        vs_d    = !enable ? ~V_POL : upd ? ((y_q >= VS_BEG && y_q < VS_END) ? V_POL : ~V_POL) : vs_q;
        r_d     = !enable ? '0 : upd ? (pix_req ? pix_r : '0) : r_q;
        g_d     = !enable ? '0 : upd ? (pix_req ? pix_g : '0) : g_q;
        b_d     = !enable ? '0 : upd ? (pix_req ? pix_b : '0) : b_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            tick_q <= 1'b0;
            run_q  <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            hs_q   <= ~H_POL;
            vs_q   <= ~V_POL;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            tick_q <= tick_d;
            run_q  <= run_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    assign pix_tick    = tick_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign red         = r_q;
    assign green       = g_q;
    assign blue        = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three geometries checked every cycle against a closed-form
// raster model driven by an enabled-clock count, plus literal timing checks.
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst, enable;
    logic [3:0] pr, pg, pb;
    int         n_assert = 0, n_fail = 0;
    longint     cyc = 0;
    bit         rnd = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       tA, qA, lA, fA, hA, vA, tB, qB, lB, fB, hB, vB, tC, qC, lC, fC, hC, vC;
    logic [9:0] xA, yA;
    logic [3:0] xB, xC, rA, gA, bA, rB, gB, bB, rC, gC, bC;
    logic [2:0] yB, yC;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .enable(enable), .pix_r(pr), .pix_g(pg), .pix_b(pb),
        .pix_tick(tA), .pix_req(qA), .x(xA), .y(yA), .line_start(lA), .frame_start(fA),
        .hsync(hA), .vsync(vA), .red(rA), .green(gA), .blue(bA));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .X_W(4), .Y_W(3)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .pix_r(pr), .pix_g(pg), .pix_b(pb),
        .pix_tick(tB), .pix_req(qB), .x(xB), .y(yB), .line_start(lB), .frame_start(fB),
        .hsync(hB), .vsync(vB), .red(rB), .green(gB), .blue(bB));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .CLK_DIV(3), .X_W(4), .Y_W(3)) u_c (
        .clk(clk), .rst(rst), .enable(enable), .pix_r(pr), .pix_g(pg), .pix_b(pb),
        .pix_tick(tC), .pix_req(qC), .x(xC), .y(yC), .line_start(lC), .frame_start(fC),
        .hsync(hC), .vsync(vC), .red(rC), .green(gC), .blue(bC));

    typedef struct {int ha, hf, hs, hb, va, vf, vs, vb, d; bit hp, vp;} geo_t;
    typedef struct packed {
        logic tick, req; logic [9:0] x, y; logic ls, fs, hs, vs; logic [11:0] rgb;
    } exp_t;

    geo_t geo [3] = '{'{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0},
                      '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1},
                      '{4, 1, 2, 1, 3, 1, 1, 1, 3, 1'b0, 1'b0}};

    // c enabled clocks since idle give n = c/d ticks; tick n shows pixel n-1 as
    // the request and the registered outputs of pixel n-2.
    function automatic exp_t model(input geo_t g, input int c, input logic [11:0] cap);
        exp_t e;
        int ht, vt, n, p, px, py;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        n = c / g.d;
        p = n > 0 ? n - 1 : 0;
        e.tick = c > 0 && c % g.d == 0;
        e.x = 10'(p % ht);
        e.y = 10'((p / ht) % vt);
        e.req = (p % ht) < g.ha && ((p / ht) % vt) < g.va;
        e.ls = e.tick && p % ht == 0;
        e.fs = e.ls && (p / ht) % vt == 0;
        e.hs = ~g.hp;
        e.vs = ~g.vp;
        e.rgb = '0;
        if (n >= 2) begin
            px = (n - 2) % ht;
            py = ((n - 2) / ht) % vt;
            if (px >= g.ha + g.hf && px < g.ha + g.hf + g.hs) e.hs = g.hp;
            if (py >= g.va + g.vf && py < g.va + g.vf + g.vs) e.vs = g.vp;
            if (px < g.ha && py < g.va) e.rgb = cap;
        end
        return e;
    endfunction

    int          c   [3] = '{0, 0, 0};
    logic [11:0] cap [3];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) c[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                c[i] <= enable ? c[i] + 1 : 0;
                if (enable && (c[i] + 1) % geo[i].d == 0) cap[i] <= {pr, pg, pb};
            end
        end
    end

    always @(negedge clk) begin
        exp_t a [3];
        exp_t e;
        a[0] = {tA, qA, xA, yA, lA, fA, hA, vA, rA, gA, bA};
        a[1] = {tB, qB, 6'd0, xB, 7'd0, yB, lB, fB, hB, vB, rB, gB, bB};
        a[2] = {tC, qC, 6'd0, xC, 7'd0, yC, lC, fC, hC, vC, rC, gC, bC};
        for (int i = 0; i < 3; i++) begin
            e = model(geo[i], c[i], cap[i]);
            n_assert++;
            if (a[i] !== e) begin
                n_fail++;
                $display("FAIL model%0d @%0t: got %h want %h", i, $time, a[i], e);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rnd) {pr, pg, pb} = 12'($urandom);
    end

    initial begin
        int k, w;
        longint t0;
        rst = 1'b0;
        enable = 1'b1;
        {pr, pg, pb} = '0;
        #50;
        chk("rst_hsync", int'(hA), 1);
        chk("rst_vsync", int'(vA), 1);
        chk("rst_rgb", int'({rA, gA, bA}), 0);
        chk("rst_pol_hsync", int'(hB), 0);
        chk("rst_pol_vsync", int'(vB), 0);
        rst = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!tA && k < 20);
        chk("first_tick_clks", k, 4);
        t0 = cyc;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!lA && k < 4000);
        chk("line_period_clks", int'(cyc - t0), 3200);
        k = 0;
        while (hA && k < 4000) begin @(posedge clk); #1; k++; end
        chk("hs_fall_x", int'(xA), 657);
        w = 1;
        k = 0;
        while (k < 4000) begin
            @(posedge clk); #1; k++;
            if (hA) break;
            if (tA) w++;
        end
        chk("hs_width_ticks", w, 96);
        k = 0;
        while (xA != 10'd300 && k < 8000) begin @(posedge clk); #1; k++; end
        chk("x300_reached", int'(xA), 300);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("drop_x", int'(xA), 0);
        chk("drop_y", int'(yA), 0);
        chk("drop_hsync", int'(hA), 1);
        chk("drop_vsync", int'(vA), 1);
        chk("drop_rgb", int'({rA, gA, bA}), 0);
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!fA && k < 20);
        chk("reenable_fs_clks", k, 4);
        k = 0;
        while (!fB && k < 100) begin @(posedge clk); #1; k++; end
        t0 = cyc;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!fB && k < 100);
        chk("frame_period_clks", int'(cyc - t0), 48);
        k = 0;
        while (!vB && k < 100) begin @(posedge clk); #1; k++; end
        chk("vs_start_y", int'(yB), 4);
        w = 1;
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1; k++;
            if (!vB) break;
            w++;
        end
        chk("vs_width_clks", w, 8);
        rnd = 1'b0;
        {pr, pg, pb} = 12'hFFF;
        @(posedge clk); #1;
        w = 0;
        k = 0;
        repeat (48) begin
            @(posedge clk); #1;
            if ({rB, gB, bB} == 12'hFFF) w++;
            else if ({rB, gB, bB} == 12'h000) k++;
        end
        chk("blank_active_clks", w, 12);
        chk("blank_zero_clks", k, 36);
        rnd = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_x", int'(xA), 0);
        chk("async_rst_tick", int'(tA), 0);
        chk("async_rst_hsync_pol", int'(hB), 0);
        chk("async_rst_rgb", int'({rA, gA, bA}), 0);
        @(negedge clk) rst = 1'b1;
        repeat (3000) begin
            @(posedge clk); #1;
            enable = $urandom_range(99) > 2;
        end
        enable = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and pixel output stage; generalises the fixed 640x480 hsync/vsync/4-bit RGB path driven from `top`.
- Derives a pixel tick from the system clock and runs horizontal/vertical counters.
- Publishes pixel request coordinates to the framebuffer/pattern source and drives registered, blank-gated RGB plus sync outputs to the board pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- CLK_DIV, 4, system clocks per pixel, >=1 (100 MHz -> 25 MHz)
- COLOR_W, 4, bits per colour channel
- X_W, 10, coordinate width, must hold H_TOTAL-1
- Y_W, 10, coordinate width, must hold V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  run raster; low = hold in idle
- pix_r  in  COLOR_W  requested pixel red, valid in same pixel period as pix_req
- pix_g  in  COLOR_W  requested pixel green
- pix_b  in  COLOR_W  requested pixel blue
- pix_tick  out  1  one-clk pulse per pixel period
- pix_req  out  1  current x,y is inside the active area
- x  out  X_W  horizontal counter value
- y  out  Y_W  vertical counter value
- line_start  out  1  one-clk pulse on tick where x wraps to 0
- frame_start  out  1  one-clk pulse on tick where x=0 and y=0
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- red  out  COLOR_W  registered, blank-gated
- green  out  COLOR_W  registered, blank-gated
- blue  out  COLOR_W  registered, blank-gated

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Async reset (rst=0):
  - div_cnt, x, y = 0; pix_tick, line_start, frame_start = 0.
  - hsync = ~H_POL, vsync = ~V_POL (inactive levels).
  - RGB = 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while enable=1.
  - pix_tick=1 on the clk where div_cnt==CLK_DIV-1.
  - CLK_DIV=1: pix_tick=1 every clk.
- Counters advance only on pix_tick:
  - x: x==H_TOTAL-1 -> x=0 and y advances.
  - y: y==V_TOTAL-1 -> y=0.
- Combinational: pix_req = (x<H_ACTIVE)&&(y<V_ACTIVE).
- Strobes are registered and high for exactly one clk, on the clk following the tick that loads the new x/y:
  - line_start when the new x=0.
  - frame_start when the new x=0 and y=0.
- Output stage, registered on pix_tick from current x,y (one pixel period latency, syncs and RGB aligned):
  - hsync = H_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vsync = V_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else ~V_POL.
  - RGB = pix_* when pix_req, else 0.
- Between ticks, all outputs hold.
- enable=0 (sampled each clk):
  - Synchronously forces the reset state on the next clk, including mid-line or mid-frame.
  - On re-enable, the raster restarts at x=0, y=0.
  - First pix_tick occurs CLK_DIV clks after enable rises.
- Reset mid-frame: immediate async return to reset state; no partial strobes.

Test Plan:
- Reset, default params: rst=0 for 50 ns then 1 -> hsync=1, vsync=1, RGB=0 during reset; first pix_tick on 4th clk after release.
- Line timing, default params: hsync low for exactly 96 ticks starting when registered x=656; period 800 ticks = 3200 clks; line_start once per line.
- Small-geometry frame (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1): frame_start every 48 clks; vsync asserted for exactly 8 clks, starting at y=4; y wraps 5->0.
- Blanking: pix_r=pix_g=pix_b=F constant -> RGB=F only for registered positions x<H_ACTIVE, y<V_ACTIVE; 0 in porches and sync.
- Polarity: H_POL=1, V_POL=1 -> reset levels 0/0; sync pulses high with the same widths.
- Enable drop: enable=0 mid-line at x=300 -> next clk x=0, y=0, syncs inactive, RGB=0; re-enable -> frame_start pulse after first tick.
